bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter for the shared system bus. It grants bus ownership to one of up to `NUM_MASTERS` requesters, for example the JTAG DMA and CPU-side masters. Ownership lasts for exactly one transaction: the arbiter tracks `begin_transaction`/`end_transaction`/`error` on the bus and releases ownership after each one. An optional watchdog revokes grants that are never used.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of requesters, 2..16.
- `GRANT_TIMEOUT`, default 16: cycles a granted master has to assert `begin_transactionIN` before the grant is revoked (watchdog build only).

Ports:
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `request`  in  NUM_MASTERS  one bit per master, level-sensitive.
- `grant`  out  NUM_MASTERS  one-hot or zero; registered.
- `grant_id`  out  4  index of the current owner; valid while `grant != 0`.
- `begin_transactionIN`  in  1  bus begin pulse from the owner.
- `end_transactionIN`  in  1  bus end pulse, from slave or owner.
- `errorIN`  in  1  bus error pulse.
- `bus_idle`  out  1  high in IDLE state.
- `timeout_pulse`  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
States and behaviour:
- **IDLE**
  - If any `request` bit is set, pick the winner by round-robin.
  - The search starts at `(last_id+1) mod NUM_MASTERS` and wraps.
  - Register the one-hot `grant` and `grant_id`, update `last_id`, go to GRANTED.
- **GRANTED**
  - `begin_transactionIN` → ACTIVE.
  - Owner's `request` low before begin → RELEASE (voluntary withdrawal).
  - Watchdog expiry → RELEASE with `timeout_pulse`.
- **ACTIVE**
  - `end_transactionIN` or `errorIN` → RELEASE.
  - `request` changes are ignored; the grant is held until the transaction ends.
- **RELEASE**
  - `grant` = 0 for one cycle (bus turnaround), then IDLE.

Simultaneous events:
- `end_transactionIN` and `errorIN` in the same cycle count as a single end.
- `begin_transactionIN` and `end_transactionIN` in the same cycle while in GRANTED: go to ACTIVE only; the end is ignored.

Other rules:
- Bus signals seen in IDLE or RELEASE are ignored.
- `grant` is never multi-hot and never changes directly from one master to another; there is always at least one zero cycle between owners.
- Reset mid-transaction drops `grant` immediately (asynchronously) and abandons the transaction.
- On reset, `last_id` = `NUM_MASTERS-1`, so master 0 has first priority.
- Out-of-range indices (`NUM_MASTERS` < 16) never win.

## Timing
- Reset values: `grant`=0, `grant_id`=0, `bus_idle`=1, `timeout_pulse`=0; state IDLE.
- Request-to-grant latency is 1 cycle from IDLE: `request` sampled at edge N gives `grant` high after edge N+1.
- End-to-next-grant: `end_transactionIN` at edge N; `grant` drops after N+1 (RELEASE); a new grant appears after N+3 at the earliest (RELEASE → IDLE → grant).
- The watchdog counter is 5-bit minimum (`$clog2(GRANT_TIMEOUT+1)`). It loads 0 on entry to GRANTED and increments each cycle in GRANTED. When it reaches `GRANT_TIMEOUT-1` without a begin, the next edge enters RELEASE and pulses `timeout_pulse` for one cycle.
- `bus_idle` and `timeout_pulse` are registered and aligned with the state.

## Configuration
- Macro `BUS_ARBITER_WATCHDOG_EN`.
  - Defined: the watchdog counter, the GRANTED-timeout transition and `timeout_pulse` are present.
  - Undefined: no counter is built, `timeout_pulse` is tied to 0, and a grant in GRANTED lasts until begin or withdrawal.

## Test plan
- **Reset:** assert `reset` with `request`=4'b1111 → `grant`=0, `bus_idle`=1. Release reset → `grant`=4'b0001 one cycle later.
- **Round-robin:** `request`=4'b1111 held, each master runs begin/end 2 cycles apart → grant order 0,1,2,3,0. There is a `grant`=0 cycle between each pair of owners.
- **Withdrawal:** grant to master 2, drop `request[2]` before begin → `grant`=0 next cycle. Master 3, if requesting, wins after IDLE.
- **Error termination:** master 1 ACTIVE, pulse `errorIN` → RELEASE, `grant`=0 one cycle later. `end_transactionIN` asserted 1 cycle later is ignored.
- **Watchdog (`GRANT_TIMEOUT`=16, macro defined):** grant to master 0, no begin → `timeout_pulse`=1 exactly 16 cycles after `grant` rose, `grant`=0 in the same cycle. With the macro undefined, `grant` holds for 100 cycles.
- **Async reset mid-ACTIVE:** pulse `reset` between edges → `grant`=0 immediately. The next grant goes to master 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin owner arbitration for the shared system bus. One master owns
//   the bus for exactly one transaction (begin .. end/error). After every
//   ownership period the grant is held at zero for one turnaround cycle.
//
//   Optional feature macro: BUS_ARBITER_WATCHDOG_EN
//     defined   - a grant that sees no begin_transactionIN within
//                 GRANT_TIMEOUT cycles is revoked and timeout_pulse fires.
//     undefined - no watchdog counter; timeout_pulse is tied low.
//
// Parameters:
//   NUM_MASTERS    number of requesters (2..16)
//   GRANT_TIMEOUT  watchdog limit in cycles (watchdog build only)
//
// Ports:
//   clock                rising-edge system clock
//   reset                asynchronous active-high reset
//   request              per-master level request
//   grant                one-hot or zero owner vector (registered)
//   grant_id             index of the current owner, valid while grant != 0
//   begin_transactionIN  begin pulse from the owner
//   end_transactionIN    end pulse from slave or owner
//   errorIN              bus error pulse (terminates like an end)
//   bus_idle             high while the arbiter is idle (registered)
//   timeout_pulse        one-cycle pulse when the watchdog revokes a grant
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS   = 4,
  parameter int unsigned GRANT_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [3:0]             grant_id,
  input  logic                   begin_transactionIN,
  input  logic                   end_transactionIN,
  input  logic                   errorIN,
  output logic                   bus_idle,
  output logic                   timeout_pulse
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || GRANT_TIMEOUT < 1) begin : g_param_check
    $error("bus_arbiter: NUM_MASTERS must be 2..16 and GRANT_TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANTED,
    ST_ACTIVE,
    ST_RELEASE
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [3:0]             grant_id_q, grant_id_d;
  logic [3:0]             last_id_q, last_id_d;
  logic                   bus_idle_q, bus_idle_d;

`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam int unsigned WD_W = ($clog2(GRANT_TIMEOUT + 1) > 5) ?
                                 $clog2(GRANT_TIMEOUT + 1) : 5;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Round-robin search. Requests are zero-padded to 16 bits so any 4-bit
  // index is legal; padded (out-of-range) positions can never win.
  logic [15:0]            req_ext;
  logic                   rr_found;
  logic [3:0]             rr_idx;
  logic [4:0]             rr_sum;
  logic [NUM_MASTERS-1:0] rr_grant;

  always_comb begin : rr_search
    req_ext  = 16'(request);
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    // Candidates in priority order: last_id+1, last_id+2, ... wrapping mod N.
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      rr_sum = {1'b0, last_id_q} + 5'(i) + 5'd1;
      if (rr_sum >= 5'(NUM_MASTERS)) begin
        rr_sum = rr_sum - 5'(NUM_MASTERS);
      end
      if (!rr_found && req_ext[rr_sum[3:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[3:0];
      end
    end
    rr_grant = NUM_MASTERS'(1) << rr_idx;
  end

  always_comb begin : next_state
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
`ifdef BUS_ARBITER_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          state_d    = ST_GRANTED;
          grant_d    = rr_grant;
          grant_id_d = rr_idx;
          last_id_d  = rr_idx;
`ifdef BUS_ARBITER_WATCHDOG_EN
          wd_cnt_d   = '0;
`endif
        end
      end
      ST_GRANTED: begin
        // begin wins over a simultaneous end, withdrawal and timeout
        if (begin_transactionIN) begin
          state_d = ST_ACTIVE;
        end else if (!req_ext[grant_id_q]) begin
          state_d = ST_RELEASE;
          grant_d = '0;
        end
`ifdef BUS_ARBITER_WATCHDOG_EN
        else if (wd_cnt_q == WD_W'(GRANT_TIMEOUT - 1)) begin
          state_d   = ST_RELEASE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      ST_ACTIVE: begin
        if (end_transactionIN || errorIN) begin
          state_d = ST_RELEASE;
          grant_d = '0;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    bus_idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= 4'(NUM_MASTERS - 1);
      bus_idle_q <= 1'b1;
`ifdef BUS_ARBITER_WATCHDOG_EN
      wd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      bus_idle_q <= bus_idle_d;
`ifdef BUS_ARBITER_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign bus_idle = bus_idle_q;
`ifdef BUS_ARBITER_WATCHDOG_EN
  assign timeout_pulse = timeout_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed stimulus, per-cycle comparison against
// an ownership model, plus literal expectations at key points.
module tb_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic         clock   = 1'b0;
  logic         reset   = 1'b1;
  logic [N-1:0] request = '0;
  logic         begin_t = 1'b0;
  logic         end_t   = 1'b0;
  logic         err     = 1'b0;
  logic [N-1:0] grant;
  logic [3:0]   grant_id;
  logic         bus_idle;
  logic         timeout_pulse;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  bus_arbiter #(.NUM_MASTERS(N), .GRANT_TIMEOUT(TO)) dut (
    .clock               (clock),
    .reset               (reset),
    .request             (request),
    .grant               (grant),
    .grant_id            (grant_id),
    .begin_transactionIN (begin_t),
    .end_transactionIN   (end_t),
    .errorIN             (err),
    .bus_idle            (bus_idle),
    .timeout_pulse       (timeout_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Ownership model: who owns the bus, whether their transaction started,
  // how long they have waited, and whether the turnaround gap is pending.
  int owner  = -1;
  bit began  = 1'b0;
  int age    = 0;
  bit turn   = 1'b0;
  int last   = N - 1;
  int cur_id = 0;
  bit to_exp = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int i = 1; i <= N; i++) begin
      if (r[(from + i) % N]) return (from + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    int w;
    if (reset) begin
      owner = -1; began = 0; age = 0; turn = 0;
      last = N - 1; cur_id = 0; to_exp = 0;
    end else begin
      to_exp = 0;
      if (owner >= 0) begin
        if (!began) begin
          if (begin_t) began = 1;
          else if (!request[owner]) begin owner = -1; turn = 1; end
`ifdef BUS_ARBITER_WATCHDOG_EN
          else if (age == TO - 1) begin owner = -1; turn = 1; to_exp = 1; end
`endif
          else age++;
        end else if (end_t || err) begin
          owner = -1; turn = 1;
        end
      end else if (turn) begin
        turn = 0;
      end else begin
        w = pick(request, last);
        if (w >= 0) begin
          owner = w; last = w; cur_id = w; began = 0; age = 0;
        end
      end
    end
  end

  always @(posedge clock) begin
    logic [N-1:0] exp_g;
    #1;
    exp_g = '0;
    if (owner >= 0) exp_g[owner] = 1'b1;
    check("model_grant", 32'(grant), 32'(exp_g));
    if (owner >= 0) check("model_grant_id", 32'(grant_id), 32'(cur_id));
    check("model_bus_idle", 32'(bus_idle), 32'(owner < 0 && !turn));
    check("model_timeout", 32'(timeout_pulse), 32'(to_exp));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  logic [N-1:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // Reset with all masters requesting
    request = 4'b1111;
    step(); step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_idle", 32'(bus_idle), 32'h1);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_timeout", 32'(timeout_pulse), 32'h0);
    reset = 1'b0;
    step();
    check("first_grant", 32'(grant), 32'h1);
    check("first_idle", 32'(bus_idle), 32'h0);

    // Round robin 0,1,2,3,0 with a zero-grant gap between owners
    for (int k = 0; k < 5; k++) begin
      check("rr_owner", 32'(grant), 32'(rr_order[k]));
      begin_t = 1'b1; step(); begin_t = 1'b0;
      check("rr_active", 32'(grant), 32'(rr_order[k]));
      step();
      end_t = 1'b1; step(); end_t = 1'b0;
      check("rr_release", 32'(grant), 32'h0);
      check("rr_release_idle", 32'(bus_idle), 32'h0);
      step();
      check("rr_idle", 32'(grant), 32'h0);
      step();
    end
    check("rr_after", 32'(grant), 32'h2);

    // Withdrawal: master 1 drops, master 2 wins, then drops, master 3 wins
    request = 4'b1100;
    step();
    check("wd1_gap", 32'(grant), 32'h0);
    step(); step();
    check("wd_m2", 32'(grant), 32'h4);
    request = 4'b1000;
    step();
    check("wd_drop", 32'(grant), 32'h0);
    step(); step();
    check("wd_m3", 32'(grant), 32'h8);
    check("wd_m3_id", 32'(grant_id), 32'h3);

    // Error termination on master 1, late end ignored
    request = 4'b0010;
    step(); step(); step();
    check("err_m1", 32'(grant), 32'h2);
    begin_t = 1'b1; step(); begin_t = 1'b0;
    err = 1'b1; step(); err = 1'b0;
    check("err_release", 32'(grant), 32'h0);
    end_t = 1'b1; request = 4'b0001; step(); end_t = 1'b0;
    check("err_late_end", 32'(grant), 32'h0);
    check("err_idle", 32'(bus_idle), 32'h1);
    step();
    check("err_next_m0", 32'(grant), 32'h1);

    // begin+end together in GRANTED: only begin counts
    begin_t = 1'b1; end_t = 1'b1; step(); begin_t = 1'b0; end_t = 1'b0;
    check("be_same", 32'(grant), 32'h1);
    step();
    check("be_still_active", 32'(grant), 32'h1);
    // end+error together: one end
    end_t = 1'b1; err = 1'b1; step(); end_t = 1'b0; err = 1'b0;
    check("ee_release", 32'(grant), 32'h0);
    step(); step();
    check("ee_regrant", 32'(grant), 32'h1);

    // Unused grant to master 0
`ifdef BUS_ARBITER_WATCHDOG_EN
    repeat (15) step();
    check("wdog_before", 32'(grant), 32'h1);
    check("wdog_before_to", 32'(timeout_pulse), 32'h0);
    step();
    check("wdog_pulse", 32'(timeout_pulse), 32'h1);
    check("wdog_revoked", 32'(grant), 32'h0);
    step();
    check("wdog_pulse_end", 32'(timeout_pulse), 32'h0);
    step();
    check("wdog_regrant", 32'(grant), 32'h1);
`else
    repeat (100) step();
    check("hold_100", 32'(grant), 32'h1);
    check("hold_no_to", 32'(timeout_pulse), 32'h0);
`endif

    // Async reset while master 0 is active; next winner is master 0 again
    request = 4'b1111;
    begin_t = 1'b1; step(); begin_t = 1'b0;
    check("ar_active", 32'(grant), 32'h1);
    #3 reset = 1'b1;
    #1;
    check("ar_grant_drop", 32'(grant), 32'h0);
    check("ar_idle", 32'(bus_idle), 32'h1);
    check("ar_grant_id", 32'(grant_id), 32'h0);
    #1 reset = 1'b0;
    step();
    check("ar_next_m0", 32'(grant), 32'h1);
    check("ar_next_id", 32'(grant_id), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
